// File: rtl/captura_jogada.sv
// Board move capture: synchronizes and debounces the 64 occupancy sensors, then turns
// lift/place events into one (origem, destino, captura) move held until limpa.
module captura_jogada #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] casas,
    input  logic        habilita,
    input  logic        limpa,
    output logic        temJogada,
    output logic [5:0]  origem,
    output logic [5:0]  destino,
    output logic        captura,
    output logic        erro,
    output logic [2:0]  db_estado
);

    typedef enum logic [2:0] {
        OCIOSO         = 3'd0,
        ESPERA_LEVANTA = 3'd1,
        ESPERA_COLOCA  = 3'd2,
        PRONTA         = 3'd3,
        ERRO           = 3'd4
    } estado_t;

    typedef struct packed {
        logic       um;
        logic [5:0] idx;
    } bit_unico_t;

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_FIRE = CW'(DEBOUNCE_CYCLES - 1);

    // um=1 only when exactly one bit of v is set; idx is then its position.
    function automatic bit_unico_t analisa(input logic [63:0] v);
        bit_unico_t r;
        logic       visto;
        logic       multi;
        r     = '0;
        visto = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (v[i]) begin
                if (visto) begin
                    multi = 1'b1;
                end else begin
                    r.idx = 6'(i);
                    visto = 1'b1;
                end
            end
        end
        r.um = visto & ~multi;
        return r;
    endfunction

    logic [63:0]   sync1_q, sync2_q, estavel_q;
    logic [63:0]   sobe_q, desce_q;
    logic [CW-1:0] cnt_q;
    logic          upd_q;

    estado_t       estado_q;
    logic [5:0]    origem_q, destino_q, cap_sq_q;
    logic          tem_q, captura_q, erro_q, cap_pend_q;

    bit_unico_t    sobe_u, desce_u;
    logic          sobe_any, desce_any;

    // NOTE: every register here is updated with <= so all flops sample the same pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            estavel_q <= '0;
            sobe_q    <= '0;
            desce_q   <= '0;
            cnt_q     <= '0;
            upd_q     <= 1'b0;
        end else begin
            sync1_q <= casas;
            sync2_q <= sync1_q;
            upd_q   <= 1'b0;
            if (sync1_q != sync2_q) begin
                cnt_q <= '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + 1'b1;
            end
            // Counter saturates, so a stable vector fires at most once; an unchanged one never.
            if ((sync1_q == sync2_q) && (cnt_q == CNT_FIRE) && (sync2_q != estavel_q)) begin
                estavel_q <= sync2_q;
                sobe_q    <= ~estavel_q & sync2_q;
                desce_q   <= estavel_q & ~sync2_q;
                upd_q     <= 1'b1;
            end
        end
    end

    assign sobe_u    = analisa(sobe_q);
    assign desce_u   = analisa(desce_q);
    assign sobe_any  = |sobe_q;
    assign desce_any = |desce_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q   <= OCIOSO;
            origem_q   <= '0;
            destino_q  <= '0;
            cap_sq_q   <= '0;
            tem_q      <= 1'b0;
            captura_q  <= 1'b0;
            erro_q     <= 1'b0;
            cap_pend_q <= 1'b0;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    if (habilita) estado_q <= ESPERA_LEVANTA;
                end
                ESPERA_LEVANTA: begin
                    if (!habilita) begin
                        estado_q <= OCIOSO;
                        origem_q <= '0;
                    end else if (upd_q) begin
                        if (desce_u.um && !sobe_any) begin
                            origem_q <= desce_u.idx;
                            estado_q <= ESPERA_COLOCA;
                        end else begin
                            erro_q   <= 1'b1;
                            estado_q <= ERRO;
                        end
                    end
                end
                ESPERA_COLOCA: begin
                    if (!habilita) begin
                        estado_q   <= OCIOSO;
                        origem_q   <= '0;
                        cap_pend_q <= 1'b0;
                        cap_sq_q   <= '0;
                    end else if (upd_q) begin
                        if (sobe_u.um && !desce_any) begin
                            if (cap_pend_q) begin
                                // After a capture the only legal landing square is the captured one.
                                if (sobe_u.idx == cap_sq_q) begin
                                    destino_q <= sobe_u.idx;
                                    captura_q <= 1'b1;
                                    tem_q     <= 1'b1;
                                    estado_q  <= PRONTA;
                                end else begin
                                    erro_q   <= 1'b1;
                                    estado_q <= ERRO;
                                end
                            end else if (sobe_u.idx == origem_q) begin
                                origem_q <= '0;
                                estado_q <= ESPERA_LEVANTA;
                            end else begin
                                destino_q <= sobe_u.idx;
                                tem_q     <= 1'b1;
                                estado_q  <= PRONTA;
                            end
                        end else if (desce_u.um && !sobe_any && !cap_pend_q) begin
                            cap_pend_q <= 1'b1;
                            cap_sq_q   <= desce_u.idx;
                        end else begin
                            erro_q   <= 1'b1;
                            estado_q <= ERRO;
                        end
                    end
                end
                PRONTA: begin
                    if (limpa) begin
                        estado_q   <= habilita ? ESPERA_LEVANTA : OCIOSO;
                        tem_q      <= 1'b0;
                        origem_q   <= '0;
                        destino_q  <= '0;
                        captura_q  <= 1'b0;
                        cap_pend_q <= 1'b0;
                        cap_sq_q   <= '0;
                    end
                end
                ERRO: begin
                    if (limpa) begin
                        estado_q   <= OCIOSO;
                        erro_q     <= 1'b0;
                        origem_q   <= '0;
                        destino_q  <= '0;
                        captura_q  <= 1'b0;
                        cap_pend_q <= 1'b0;
                        cap_sq_q   <= '0;
                    end
                end
                default: estado_q <= OCIOSO;
            endcase
        end
    end

    assign temJogada = tem_q;
    assign origem    = origem_q;
    assign destino   = destino_q;
    assign captura   = captura_q;
    assign erro      = erro_q;
    assign db_estado = estado_q;

endmodule

// File: tb/tb_captura_jogada.sv
// Directed bench for captura_jogada: expected outputs are queued as each stimulus step is
// driven and compared once the debounced result has had time to reach the outputs.
module tb_captura_jogada;

    logic        clock;
    logic        reset;
    logic [63:0] casas;
    logic        habilita;
    logic        limpa;
    logic        temJogada;
    logic [5:0]  origem;
    logic [5:0]  destino;
    logic        captura;
    logic        erro;
    logic [2:0]  db_estado;

    captura_jogada #(.DEBOUNCE_CYCLES(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .casas     (casas),
        .habilita  (habilita),
        .limpa     (limpa),
        .temJogada (temJogada),
        .origem    (origem),
        .destino   (destino),
        .captura   (captura),
        .erro      (erro),
        .db_estado (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0] st;
        logic       tem;
        logic       err;
        logic       mv;
        logic [5:0] org;
        logic [5:0] dst;
        logic       cap;
    } exp_t;

    localparam logic [63:0] INICIO = 64'hFFFF_0000_0000_FFFF;

    exp_t        exp_q[$];
    string       tag_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [63:0] tab;

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic sb_push(input string tag, input logic [2:0] st, input logic tem,
                           input logic err, input logic mv, input logic [5:0] org,
                           input logic [5:0] dst, input logic cap);
        exp_t e;
        e.st  = st;
        e.tem = tem;
        e.err = err;
        e.mv  = mv;
        e.org = org;
        e.dst = dst;
        e.cap = cap;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic sb_check();
        exp_t  e;
        string t;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL sb_empty got=0 want=1");
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            total++;
            assert (db_estado === e.st) else begin
                bad++;
                $error("FAIL %s db_estado got=%0d want=%0d", t, db_estado, e.st);
            end
            total++;
            assert (temJogada === e.tem) else begin
                bad++;
                $error("FAIL %s temJogada got=%0b want=%0b", t, temJogada, e.tem);
            end
            total++;
            assert (erro === e.err) else begin
                bad++;
                $error("FAIL %s erro got=%0b want=%0b", t, erro, e.err);
            end
            if (e.mv) begin
                total++;
                assert (origem === e.org) else begin
                    bad++;
                    $error("FAIL %s origem got=%0d want=%0d", t, origem, e.org);
                end
                total++;
                assert (destino === e.dst) else begin
                    bad++;
                    $error("FAIL %s destino got=%0d want=%0d", t, destino, e.dst);
                end
                total++;
                assert (captura === e.cap) else begin
                    bad++;
                    $error("FAIL %s captura got=%0b want=%0b", t, captura, e.cap);
                end
            end
        end
    endtask

    // Drive a new board and wait well past sync + debounce + FSM latency.
    task automatic mexe(input logic [63:0] v);
        casas = v;
        tick(10);
    endtask

    task automatic pulsa_limpa();
        limpa = 1'b1;
        tick(1);
        limpa = 1'b0;
    endtask

    // Rearrange pieces with capture disabled, then re-enable in ESPERA_LEVANTA.
    task automatic recarrega(input logic [63:0] v);
        habilita = 1'b0;
        tick(2);
        mexe(v);
        habilita = 1'b1;
        tick(2);
    endtask

    initial begin
        reset    = 1'b0;
        casas    = INICIO;
        habilita = 1'b0;
        limpa    = 1'b0;
        tab      = INICIO;

        #12;
        sb_push("reset", 3'd0, 1'b0, 1'b0, 1'b1, 6'd0, 6'd0, 1'b0);
        sb_check();
        @(negedge clock);
        reset = 1'b1;
        tick(12);
        sb_push("ocioso_pos_reset", 3'd0, 1'b0, 1'b0, 1'b1, 6'd0, 6'd0, 1'b0);
        sb_check();
        habilita = 1'b1;
        tick(2);
        sb_push("habilita", 3'd1, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 1'b0);
        sb_check();

        // Simple move e2-e4
        tab[12] = 1'b0;
        mexe(tab);
        sb_push("levanta_e2", 3'd2, 1'b0, 1'b0, 1'b1, 6'd12, 6'd0, 1'b0);
        sb_check();
        tab[28] = 1'b1;
        mexe(tab);
        sb_push("jogada_e2e4", 3'd3, 1'b1, 1'b0, 1'b1, 6'd12, 6'd28, 1'b0);
        sb_check();
        pulsa_limpa();
        sb_push("limpa_pronta", 3'd1, 1'b0, 1'b0, 1'b1, 6'd0, 6'd0, 1'b0);
        sb_check();

        // Capture 28x35
        tab[35] = 1'b1;
        recarrega(tab);
        sb_push("coloca_35", 3'd1, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 1'b0);
        sb_check();
        tab[28] = 1'b0;
        mexe(tab);
        sb_push("levanta_28", 3'd2, 1'b0, 1'b0, 1'b1, 6'd28, 6'd0, 1'b0);
        sb_check();
        tab[35] = 1'b0;
        mexe(tab);
        sb_push("remove_35", 3'd2, 1'b0, 1'b0, 1'b1, 6'd28, 6'd0, 1'b0);
        sb_check();
        tab[35] = 1'b1;
        mexe(tab);
        sb_push("captura_35", 3'd3, 1'b1, 1'b0, 1'b1, 6'd28, 6'd35, 1'b1);
        sb_check();
        pulsa_limpa();
        sb_push("limpa_captura", 3'd1, 1'b0, 1'b0, 1'b1, 6'd0, 6'd0, 1'b0);
        sb_check();

        // Capture landing on the wrong square
        tab[44] = 1'b1;
        recarrega(tab);
        tab[35] = 1'b0;
        mexe(tab);
        sb_push("levanta_35", 3'd2, 1'b0, 1'b0, 1'b1, 6'd35, 6'd0, 1'b0);
        sb_check();
        tab[44] = 1'b0;
        mexe(tab);
        sb_push("remove_44", 3'd2, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 1'b0);
        sb_check();
        tab[36] = 1'b1;
        mexe(tab);
        sb_push("captura_errada", 3'd4, 1'b0, 1'b1, 1'b0, 6'd0, 6'd0, 1'b0);
        sb_check();
        pulsa_limpa();
        sb_push("limpa_erro", 3'd0, 1'b0, 1'b0, 1'b1, 6'd0, 6'd0, 1'b0);
        sb_check();
        tick(1);
        sb_push("reabilita", 3'd1, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 1'b0);
        sb_check();

        // Short bounce on e2 is filtered out
        tab = INICIO;
        recarrega(tab);
        casas = tab & ~(64'd1 << 12);
        tick(3);
        casas = tab;
        tick(10);
        sb_push("bounce", 3'd1, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 1'b0);
        sb_check();

        // Two squares lifted together
        tab[12] = 1'b0;
        tab[13] = 1'b0;
        mexe(tab);
        sb_push("duas_casas", 3'd4, 1'b0, 1'b1, 1'b0, 6'd0, 6'd0, 1'b0);
        sb_check();
        pulsa_limpa();
        sb_push("limpa_erro2", 3'd0, 1'b0, 1'b0, 1'b1, 6'd0, 6'd0, 1'b0);
        sb_check();
        tick(1);
        sb_push("reabilita2", 3'd1, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 1'b0);
        sb_check();

        // Piece returned to origin, then abort by habilita=0
        tab = INICIO;
        recarrega(tab);
        tab[12] = 1'b0;
        mexe(tab);
        sb_push("levanta_12", 3'd2, 1'b0, 1'b0, 1'b1, 6'd12, 6'd0, 1'b0);
        sb_check();
        tab[12] = 1'b1;
        mexe(tab);
        sb_push("devolve_12", 3'd1, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 1'b0);
        sb_check();
        tab[12] = 1'b0;
        mexe(tab);
        sb_push("levanta_12b", 3'd2, 1'b0, 1'b0, 1'b1, 6'd12, 6'd0, 1'b0);
        sb_check();
        habilita = 1'b0;
        tick(1);
        sb_push("desabilita", 3'd0, 1'b0, 1'b0, 1'b1, 6'd0, 6'd0, 1'b0);
        sb_check();

        // Asynchronous reset in ESPERA_COLOCA
        recarrega(tab);
        tab[13] = 1'b0;
        mexe(tab);
        sb_push("levanta_13", 3'd2, 1'b0, 1'b0, 1'b1, 6'd13, 6'd0, 1'b0);
        sb_check();
        #2;
        reset = 1'b0;
        #1;
        sb_push("reset_meio", 3'd0, 1'b0, 1'b0, 1'b1, 6'd0, 6'd0, 1'b0);
        sb_check();
        @(negedge clock);
        reset = 1'b1;
        // habilita is still 1: the first post-reset update carries many sobe bits
        tick(12);
        sb_push("habilita_cedo", 3'd4, 1'b0, 1'b1, 1'b0, 6'd0, 6'd0, 1'b0);
        sb_check();
        pulsa_limpa();
        sb_push("limpa_erro3", 3'd0, 1'b0, 1'b0, 1'b1, 6'd0, 6'd0, 1'b0);
        sb_check();
        tick(1);
        sb_push("reabilita3", 3'd1, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 1'b0);
        sb_check();

        // PRONTA ignores habilita=0; limpa with habilita=1 returns to ESPERA_LEVANTA
        tab[14] = 1'b0;
        mexe(tab);
        sb_push("levanta_14", 3'd2, 1'b0, 1'b0, 1'b1, 6'd14, 6'd0, 1'b0);
        sb_check();
        tab[30] = 1'b1;
        mexe(tab);
        sb_push("jogada_14_30", 3'd3, 1'b1, 1'b0, 1'b1, 6'd14, 6'd30, 1'b0);
        sb_check();
        habilita = 1'b0;
        tick(3);
        sb_push("pronta_ignora_hab", 3'd3, 1'b1, 1'b0, 1'b1, 6'd14, 6'd30, 1'b0);
        sb_check();
        habilita = 1'b1;
        pulsa_limpa();
        sb_push("limpa_com_hab", 3'd1, 1'b0, 1'b0, 1'b1, 6'd0, 6'd0, 1'b0);
        sb_check();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
